fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and fetch-control stage; sits directly downstream of the control decoder and upstream of the instruction ROM.
- Consumes the decoder's PCTarg, BranchEn, Jump and Ack, plus the ALU flags.
- Produces the registered ProgCtr that addresses the instruction ROM, a run/done handshake to the testbench, and a saturating executed-cycle counter.
- Contains the branch-target LUT that PCTarg indexes.

Parameters:
PC_W, 10, program counter / target width in bits
SEL_W, 3, width of PCTarg (LUT depth = 2**SEL_W)
CNT_W, 16, width of executed-cycle counter
START_ADDR, 0, PC value loaded on reset and on every Start

Ports:
Clk  input  1  single system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  one-cycle pulse, begin/restart program
PCTarg  input  SEL_W  index into target LUT (from decoder)
BranchEn  input  2  branch condition select (from decoder)
Jump  input  1  unconditional jump to LUT target (from decoder)
Ack  input  1  halt instruction decoded (from decoder)
ZeroFlag  input  1  ALU zero result flag
NegFlag  input  1  ALU negative result flag
ProgCtr  output  PC_W  registered instruction address to ROM
Running  output  1  high while in RUN
Done  output  1  high while in DONE (program finished)
CycleCnt  output  CNT_W  number of RUN cycles since last Start

Behaviour:
- Interface: one clock, Clk; Reset is asynchronous and active-high.
- Reset effects, applied immediately: state=IDLE, ProgCtr=START_ADDR, Running=0, Done=0, CycleCnt=0. This holds even mid-program.
- All outputs are registered and change only on Clk rising edges, except the asynchronous reset.
- States are IDLE, RUN and DONE.
- IDLE:
  - Decoder inputs are ignored.
  - Start=1 → next cycle: RUN, ProgCtr=START_ADDR, CycleCnt=0.
- RUN: evaluated every cycle, priority order Ack > Jump > taken branch > increment.
  - Ack=1: next state DONE; ProgCtr holds. CycleCnt still increments for this cycle.
  - Jump=1: ProgCtr ← TARGET_LUT[PCTarg].
  - Taken branch: ProgCtr ← TARGET_LUT[PCTarg]. Taken rules by BranchEn:
    - 00: never taken.
    - 01: taken if ZeroFlag=1.
    - 10: taken if ZeroFlag=0.
    - 11: taken if NegFlag=1.
  - Otherwise: ProgCtr ← ProgCtr+1, modulo 2**PC_W. Wrap from all-ones to 0 is silent, with no flag.
  - CycleCnt increments by 1 each RUN cycle and saturates at all-ones.
  - Start in RUN is ignored.
- Latency: decoder/flag inputs sampled at edge N give the new ProgCtr visible after edge N. This is one cycle, with no delay slot.
- DONE:
  - Done=1, Running=0; ProgCtr and CycleCnt frozen.
  - Decoder inputs are ignored.
  - Start=1 → RUN with ProgCtr=START_ADDR and CycleCnt=0. Done drops the same edge.
- Running and Done are never both 1.
- Target LUT: combinational, depth 2**SEL_W, PC_W-wide absolute addresses. Contents come from a package constant.
- Simultaneous Ack with Jump or branch: Ack wins, PC does not move.

Decomposition:
- Shared package (definitions) holds:
  - fetch_state_t enum {IDLE, RUN, DONE}
  - BR_NONE/BR_ZERO/BR_NZERO/BR_NEG codes for BranchEn
  - the TARGET_LUT constant array.
  - Shipped defaults: entry 0=0, 1=8, 2=20, 3=40, 4=64, 5=100, 6=200, 7=500.
- One sub-module, target_lut: combinational PCTarg → target address.
- State machine, PC register and counter stay in fetch_unit.

Test Plan:
1. Reset asserted mid-RUN at ProgCtr=7 → ProgCtr=0, Running=0, Done=0, CycleCnt=0 immediately, before the next edge.
2. Start pulse, then no control inputs for 5 cycles → ProgCtr 0,1,2,3,4,5; CycleCnt=5; Running=1.
3. At ProgCtr=6, Jump=1, PCTarg=3 → next ProgCtr=40. At ProgCtr=40, BranchEn=01, ZeroFlag=0 → 41. Then BranchEn=01, ZeroFlag=1, PCTarg=5 → 100.
4. BranchEn=11, NegFlag=1, PCTarg=4 → 64. BranchEn=10, ZeroFlag=0, PCTarg=7 → 500. Same cycle as Jump=1 with Ack=1 → ProgCtr holds, Done=1 next cycle.
5. ProgCtr=1023 with no branch → ProgCtr=0. Force CycleCnt to 65535 over a long run → stays 65535.
6. In DONE, pulse Jump/Ack for 3 cycles → no change. Pulse Start → ProgCtr=0, Running=1, Done=0, CycleCnt=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM states, branch-condition codes,
// the branch-target table contents and the branch-condition evaluation.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        BR_NONE  = 2'b00,
        BR_ZERO  = 2'b01,
        BR_NZERO = 2'b10,
        BR_NEG   = 2'b11
    } br_sel_t;

    // Absolute branch/jump targets; indices beyond the table read as 0.
    localparam int LUT_DEPTH = 8;
    localparam int TARGET_LUT [LUT_DEPTH] = '{0, 8, 20, 40, 64, 100, 200, 500};

    function automatic logic branch_taken(input br_sel_t sel, input logic zero, input logic neg);
        case (sel)
            BR_ZERO:  return zero;
            BR_NZERO: return !zero;
            BR_NEG:   return neg;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_unit_target_lut.sv
// Combinational branch-target table: maps the decoder's PCTarg index to an
// absolute PC_W-wide instruction address.
module target_lut
    import fetch_unit_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0] i_sel,
    output logic [PC_W-1:0]  o_addr
);

    always_comb begin
        // NOTE: default assignment first so no path leaves o_addr unassigned (no latch).
        o_addr = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (int'(i_sel) == i) begin
                o_addr = PC_W'(TARGET_LUT[i]);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch control: IDLE/RUN/DONE sequencing, branch/jump
// redirection through the target table, and a saturating RUN-cycle counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 16,
    parameter int START_ADDR = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [SEL_W-1:0] PCTarg,
    input  logic [1:0]       BranchEn,
    input  logic             Jump,
    input  logic             Ack,
    input  logic             ZeroFlag,
    input  logic             NegFlag,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_t    r_state;
    logic [PC_W-1:0] w_target;
    logic            w_redirect;

    target_lut #(
        .PC_W  (PC_W),
        .SEL_W (SEL_W)
    ) u_target_lut (
        .i_sel  (PCTarg),
        .o_addr (w_target)
    );

    assign w_redirect = Jump || branch_taken(br_sel_t'(BranchEn), ZeroFlag, NegFlag);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            ProgCtr  <= START_PC;
            Running  <= 1'b0;
            Done     <= 1'b0;
            CycleCnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (CycleCnt != '1) begin
                        CycleCnt <= CycleCnt + CNT_W'(1);
                    end
                    // Ack outranks any redirect: the PC stays on the halt instruction.
                    if (Ack) begin
                        r_state <= DONE;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                    end else if (w_redirect) begin
                        ProgCtr <= w_target;
                    end else begin
                        ProgCtr <= ProgCtr + PC_W'(1);
                    end
                end
                default: begin
                    if (Start) begin
                        r_state  <= RUN;
                        ProgCtr  <= START_PC;
                        Running  <= 1'b1;
                        Done     <= 1'b0;
                        CycleCnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected outputs,
// a monitor pops and compares them half a cycle after each active edge.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  PCTarg;
    logic [1:0]  BranchEn;
    logic        Jump;
    logic        Ack;
    logic        ZeroFlag;
    logic        NegFlag;
    logic [9:0]  ProgCtr;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCnt;

    typedef struct {
        string       name;
        logic [9:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    event mon_ev;

    fetch_unit dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .PCTarg   (PCTarg),
        .BranchEn (BranchEn),
        .Jump     (Jump),
        .Ack      (Ack),
        .ZeroFlag (ZeroFlag),
        .NegFlag  (NegFlag),
        .ProgCtr  (ProgCtr),
        .Running  (Running),
        .Done     (Done),
        .CycleCnt (CycleCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input exp_t e);
        checks++;
        if (ProgCtr !== e.pc || Running !== e.run || Done !== e.done || CycleCnt !== e.cnt) begin
            errors++;
            $display("FAIL %s: got pc=%0d run=%b done=%b cnt=%0d, expected pc=%0d run=%b done=%b cnt=%0d",
                     e.name, ProgCtr, Running, Done, CycleCnt, e.pc, e.run, e.done, e.cnt);
        end
    endtask

    task automatic expect_out(input string nm, input int pc, input bit run, input bit done, input int cnt);
        exp_t e;
        e.name = nm;
        e.pc   = 10'(pc);
        e.run  = run;
        e.done = done;
        e.cnt  = 16'(cnt);
        sb_q.push_back(e);
    endtask

    task automatic step(input bit st, input int tg, input int be, input bit jp, input bit ak,
                        input bit zf, input bit nf, input string nm,
                        input int pc, input bit run, input bit done, input int cnt);
        @(negedge Clk);
        Start    = st;
        PCTarg   = 3'(tg);
        BranchEn = 2'(be);
        Jump     = jp;
        Ack      = ak;
        ZeroFlag = zf;
        NegFlag  = nf;
        @(posedge Clk);
        #1;
        expect_out(nm, pc, run, done, cnt);
    endtask

    initial begin
        forever begin
            @(negedge Clk or mon_ev);
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check(e);
            end
        end
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; PCTarg = '0; BranchEn = '0;
        Jump = 1'b0; Ack = 1'b0; ZeroFlag = 1'b0; NegFlag = 1'b0;
        repeat (2) @(posedge Clk);
        #1 expect_out("reset_state", 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b0;

        // IDLE ignores decoder inputs
        step(0, 3, 1, 1, 1, 1, 1, "idle_ignore", 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, "start", 0, 1, 0, 0);
        for (int i = 1; i <= 6; i++) step(0, 0, 0, 0, 0, 0, 0, "increment", i, 1, 0, i);

        // Jumps and branches: args are start, targ, branchen, jump, ack, zero, neg
        step(0, 3, 0, 1, 0, 0, 0, "jump_t3",        40,  1, 0, 7);
        step(0, 5, 1, 0, 0, 0, 0, "bz_not_taken",   41,  1, 0, 8);
        step(0, 5, 1, 0, 0, 1, 0, "bz_taken",       100, 1, 0, 9);
        step(0, 5, 0, 0, 0, 1, 1, "bnone",          101, 1, 0, 10);
        step(0, 4, 3, 0, 0, 0, 1, "bneg_taken",     64,  1, 0, 11);
        step(0, 4, 3, 0, 0, 1, 0, "bneg_not_taken", 65,  1, 0, 12);
        step(0, 7, 2, 0, 0, 0, 0, "bnz_taken",      500, 1, 0, 13);
        step(0, 7, 2, 0, 0, 1, 0, "bnz_not_taken",  501, 1, 0, 14);
        step(1, 0, 0, 0, 0, 0, 0, "start_in_run",   502, 1, 0, 15);
        step(0, 1, 0, 1, 0, 0, 0, "jump_t1",        8,   1, 0, 16);
        step(0, 3, 1, 1, 1, 1, 0, "ack_over_jump",  8,   0, 1, 17);

        // DONE freezes everything until Start
        step(0, 3, 0, 1, 1, 0, 0, "done_hold_a",    8,   0, 1, 17);
        step(0, 5, 1, 0, 1, 1, 0, "done_hold_b",    8,   0, 1, 17);
        step(0, 7, 3, 1, 0, 0, 1, "done_hold_c",    8,   0, 1, 17);
        step(1, 0, 0, 0, 0, 0, 0, "done_restart",   0,   1, 0, 0);
        for (int i = 1; i <= 7; i++) step(0, 0, 0, 0, 0, 0, 0, "run_to_7", i, 1, 0, i);

        // Asynchronous reset mid-program, observed before the next edge
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1 expect_out("async_reset", 0, 0, 0, 0);
        ->mon_ev;
        @(posedge Clk);
        #1 expect_out("reset_hold", 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Long run: PC wrap at 1023 and counter saturation at 65535
        step(1, 0, 0, 0, 0, 0, 0, "long_start", 0, 1, 0, 0);
        for (int i = 1; i <= 65540; i++) begin
            step(0, 0, 0, 0, 0, 0, 0,
                 (i == 1024) ? "pc_wrap" : (i >= 65535) ? "cnt_sat" : "long_run",
                 i % 1024, 1, 0, (i > 65535) ? 65535 : i);
        end
        step(0, 2, 0, 0, 1, 0, 0, "ack_saturated", 4, 0, 1, 65535);
        step(1, 0, 0, 0, 0, 0, 0, "final_restart", 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, "final_inc",     1, 1, 0, 1);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge Clk);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
